// File: rtl/aftab_csr_access_unit.sv
// AFTAB CSR access unit.
// Holds the implemented CSR storage for the interrupt/trap subsystem and
// services read-modify-write requests (RW / RS / RC) from the datapath
// controller. Each request takes three cycles: capture, read/check, write.
// The old CSR value and an illegal-access flag come back as a one-cycle
// response pulse. The trap-relevant registers are also exported as live taps.

module aftab_csr_access_unit #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   MTVEC_RESET = '0,
    parameter logic [XLEN-1:0]   UTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reqValid,
    output logic            reqReady,
    input  logic [1:0]      reqOp,
    input  logic [11:0]     reqAddr,
    input  logic [XLEN-1:0] reqWData,
    input  logic            reqSrcZero,
    input  logic [1:0]      curPriv,
    output logic            respValid,
    output logic [XLEN-1:0] respRData,
    output logic            respIllegal,
    output logic [XLEN-1:0] mstatusOut,
    output logic [XLEN-1:0] mieOut,
    output logic [XLEN-1:0] mtvecOut,
    output logic [XLEN-1:0] mepcOut
);

    // Operation encodings; 2'b00 is reserved and always illegal.
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // Storage slots for the 19 implemented CSRs.
    localparam int         NUM_CSR     = 19;
    localparam logic [4:0] IDX_MSTATUS = 5'd0;
    localparam logic [4:0] IDX_MEDELEG = 5'd1;
    localparam logic [4:0] IDX_MIDELEG = 5'd2;
    localparam logic [4:0] IDX_MIE     = 5'd3;
    localparam logic [4:0] IDX_MTVEC   = 5'd4;
    localparam logic [4:0] IDX_MEPC    = 5'd5;
    localparam logic [4:0] IDX_MCAUSE  = 5'd6;
    localparam logic [4:0] IDX_MTVAL   = 5'd7;
    localparam logic [4:0] IDX_MIP     = 5'd8;
    localparam logic [4:0] IDX_USTATUS = 5'd9;
    localparam logic [4:0] IDX_UIE     = 5'd10;
    localparam logic [4:0] IDX_UTVEC   = 5'd11;
    localparam logic [4:0] IDX_UEPC    = 5'd12;
    localparam logic [4:0] IDX_UCAUSE  = 5'd13;
    localparam logic [4:0] IDX_UTVAL   = 5'd14;
    localparam logic [4:0] IDX_UIP     = 5'd15;
    localparam logic [4:0] IDX_FFLAGS  = 5'd16;
    localparam logic [4:0] IDX_FRM     = 5'd17;
    localparam logic [4:0] IDX_FCSR    = 5'd18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state_q;

    // Request fields captured at acceptance.
    logic [1:0]      latchOp_q;
    logic [11:0]     latchAddr_q;
    logic [XLEN-1:0] latchWData_q;
    logic            latchSrcZero_q;
    logic [1:0]      latchPriv_q;

    // Write decided during READ and committed at the end of WRITE.
    logic            writeEn_q;
    logic [4:0]      writeIdx_q;
    logic [XLEN-1:0] writeData_q;

    // Registered response and handshake outputs.
    logic            reqReady_q;
    logic            respValid_q;
    logic [XLEN-1:0] respRData_q;
    logic            respIllegal_q;

    // CSR storage.
    logic [XLEN-1:0] csr_q [NUM_CSR];

    // Combinational decode of the captured request.
    logic            csrHit;
    logic [4:0]      csrIdx;
    logic [XLEN-1:0] oldValue;
    logic            writeIntent;
    logic            illegal_d;
    logic [XLEN-1:0] newValue_d;

    // Maps a CSR address to {implemented, storage slot}.
    function automatic logic [5:0] lookupCsr(input logic [11:0] addr);
        logic [5:0] result;
        result = 6'd0;
        case (addr)
            12'h300: result = {1'b1, IDX_MSTATUS};
            12'h302: result = {1'b1, IDX_MEDELEG};
            12'h303: result = {1'b1, IDX_MIDELEG};
            12'h304: result = {1'b1, IDX_MIE};
            12'h305: result = {1'b1, IDX_MTVEC};
            12'h341: result = {1'b1, IDX_MEPC};
            12'h342: result = {1'b1, IDX_MCAUSE};
            12'h343: result = {1'b1, IDX_MTVAL};
            12'h344: result = {1'b1, IDX_MIP};
            12'h000: result = {1'b1, IDX_USTATUS};
            12'h004: result = {1'b1, IDX_UIE};
            12'h005: result = {1'b1, IDX_UTVEC};
            12'h041: result = {1'b1, IDX_UEPC};
            12'h042: result = {1'b1, IDX_UCAUSE};
            12'h043: result = {1'b1, IDX_UTVAL};
            12'h044: result = {1'b1, IDX_UIP};
            12'h001: result = {1'b1, IDX_FFLAGS};
            12'h002: result = {1'b1, IDX_FRM};
            12'h003: result = {1'b1, IDX_FCSR};
            default: result = 6'd0;
        endcase
        return result;
    endfunction

    // Decodes the captured request: existence, legality, old value and the new value.
    always_comb begin
        csrHit      = 1'b0;
        csrIdx      = 5'd0;
        oldValue    = '0;
        writeIntent = 1'b0;
        illegal_d   = 1'b0;
        newValue_d  = '0;

        {csrHit, csrIdx} = lookupCsr(latchAddr_q);

        if (csrHit) begin
            oldValue = csr_q[csrIdx];
        end

        // RW always writes. RS/RC write only when the source operand is non-zero.
        writeIntent = (latchOp_q == OP_RW) ||
                      (((latchOp_q == OP_RS) || (latchOp_q == OP_RC)) && !latchSrcZero_q);

        illegal_d = !csrHit ||
                    (latchOp_q == 2'b00) ||
                    (latchAddr_q[9:8] > latchPriv_q) ||
                    ((latchAddr_q[11:10] == 2'b11) && writeIntent);

        case (latchOp_q)
            OP_RW:   newValue_d = latchWData_q;
            OP_RS:   newValue_d = oldValue | latchWData_q;
            OP_RC:   newValue_d = oldValue & ~latchWData_q;
            default: newValue_d = oldValue;
        endcase
    end

    // Request sequencer: capture in IDLE, read/check in READ, respond and commit in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            latchOp_q      <= 2'b00;
            latchAddr_q    <= 12'd0;
            latchWData_q   <= '0;
            latchSrcZero_q <= 1'b0;
            latchPriv_q    <= 2'b00;
            writeEn_q      <= 1'b0;
            writeIdx_q     <= 5'd0;
            writeData_q    <= '0;
            reqReady_q     <= 1'b1;
            respValid_q    <= 1'b0;
            respRData_q    <= '0;
            respIllegal_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    respValid_q <= 1'b0;
                    writeEn_q   <= 1'b0;
                    if (reqValid) begin
                        latchOp_q      <= reqOp;
                        latchAddr_q    <= reqAddr;
                        latchWData_q   <= reqWData;
                        latchSrcZero_q <= reqSrcZero;
                        latchPriv_q    <= curPriv;
                        reqReady_q     <= 1'b0;
                        state_q        <= READ;
                    end
                end
                READ: begin
                    respRData_q   <= illegal_d ? '0 : oldValue;
                    respIllegal_q <= illegal_d;
                    writeEn_q     <= !illegal_d && writeIntent;
                    writeIdx_q    <= csrIdx;
                    writeData_q   <= newValue_d;
                    respValid_q   <= 1'b1;
                    state_q       <= WRITE;
                end
                WRITE: begin
                    respValid_q <= 1'b0;
                    writeEn_q   <= 1'b0;
                    reqReady_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    respValid_q <= 1'b0;
                    writeEn_q   <= 1'b0;
                    reqReady_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // CSR storage: reset values, then the single committed write at the end of WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                csr_q[i] <= '0;
            end
            csr_q[IDX_MTVEC] <= MTVEC_RESET;
            csr_q[IDX_UTVEC] <= UTVEC_RESET;
        end else if ((state_q == WRITE) && writeEn_q) begin
            csr_q[writeIdx_q] <= writeData_q;
        end
    end

    assign reqReady    = reqReady_q;
    assign respValid   = respValid_q;
    assign respRData   = respRData_q;
    assign respIllegal = respIllegal_q;

    assign mstatusOut  = csr_q[IDX_MSTATUS];
    assign mieOut      = csr_q[IDX_MIE];
    assign mtvecOut    = csr_q[IDX_MTVEC];
    assign mepcOut     = csr_q[IDX_MEPC];

endmodule

// File: tb/tb_aftab_csr_access_unit.sv
// Testbench for aftab_csr_access_unit.
// Requests are issued by applyStimulus. An associative-array CSR model
// predicts each response, and the prediction is pushed onto a scoreboard.
// A negedge monitor pops an entry and compares it whenever respValid is seen.

module tb_aftab_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic [11:0] reqAddr;
    logic [31:0] reqWData;
    logic        reqSrcZero;
    logic [1:0]  curPriv;
    logic        respValid;
    logic [31:0] respRData;
    logic        respIllegal;
    logic [31:0] mstatusOut;
    logic [31:0] mieOut;
    logic [31:0] mtvecOut;
    logic [31:0] mepcOut;

    aftab_csr_access_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0000),
        .UTVEC_RESET (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqOp       (reqOp),
        .reqAddr     (reqAddr),
        .reqWData    (reqWData),
        .reqSrcZero  (reqSrcZero),
        .curPriv     (curPriv),
        .respValid   (respValid),
        .respRData   (respRData),
        .respIllegal (respIllegal),
        .mstatusOut  (mstatusOut),
        .mieOut      (mieOut),
        .mtvecOut    (mtvecOut),
        .mepcOut     (mepcOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        int          acceptCycle;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } expect_t;

    expect_t     sbQueue[$];
    logic [31:0] modelCsr [int];
    int          implAddrs [19] = '{'h300, 'h302, 'h303, 'h304, 'h305, 'h341, 'h342, 'h343, 'h344,
                                    'h000, 'h004, 'h005, 'h041, 'h042, 'h043, 'h044,
                                    'h001, 'h002, 'h003};
    int          badAddrs [5] = '{'h7C0, 'hC00, 'h301, 'h345, 'h3A0};

    int          nCompares = 0;
    int          nMiss = 0;
    int          cycleCnt = 0;
    int          lastAccept = 0;
    int          lastWaits = 0;
    bit          trackBusy = 1'b0;
    bit          tapPending = 1'b0;
    expect_t     tapExp;

    // Free-running cycle counter. The monitor measures latency against it.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Hard stop in case the bench itself gets stuck somewhere unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompares++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic reportFailure(input string name);
        nCompares++;
        nMiss++;
        $display("[TB] FAIL %s: got timeout, expected completion (t=%0t)", name, $time);
    endtask

    function automatic void modelReset();
        modelCsr.delete();
        foreach (implAddrs[i]) modelCsr[implAddrs[i]] = 32'h0;
    endfunction

    // Drives one request and holds it until the unit accepts it.
    // When expectResp is set, the predicted outcome is queued.
    // The task returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                                 input logic sz, input logic [1:0] priv, input bit expectResp);
        expect_t     e;
        int          waits;
        bit          ill;
        bit          wr;
        logic [31:0] old;
        reqOp      = op;
        reqAddr    = addr;
        reqWData   = wd;
        reqSrcZero = sz;
        curPriv    = priv;
        reqValid   = 1'b1;
        waits      = 0;
        while (!reqReady && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!reqReady) begin
            reportFailure("acceptTimeout");
            reqValid = 1'b0;
            return;
        end
        lastWaits = waits;
        if (expectResp) begin
            wr  = (op == 2'b01) || ((op != 2'b00) && !sz);
            ill = !modelCsr.exists(int'(addr)) || (op == 2'b00) ||
                  (addr[9:8] > priv) || ((addr[11:10] == 2'b11) && wr);
            old = ill ? 32'h0 : modelCsr[int'(addr)];
            if (!ill && wr) begin
                if (op == 2'b01)      modelCsr[int'(addr)] = wd;
                else if (op == 2'b10) modelCsr[int'(addr)] = old | wd;
                else                  modelCsr[int'(addr)] = old & ~wd;
            end
            e.rdata       = old;
            e.illegal     = ill;
            e.acceptCycle = cycleCnt + 1;
            e.mstatus     = modelCsr['h300];
            e.mie         = modelCsr['h304];
            e.mtvec       = modelCsr['h305];
            e.mepc        = modelCsr['h341];
            sbQueue.push_back(e);
            lastAccept = cycleCnt + 1;
            trackBusy  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drops reqValid and waits until every queued response has been seen and
    // the unit is idle. Then allows one more cycle so the tap check can run.
    task automatic waitIdle();
        int n;
        reqValid = 1'b0;
        n = 0;
        while ((sbQueue.size() != 0 || !reqReady) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbQueue.size() != 0 || !reqReady) begin
            reportFailure("idleTimeout");
            sbQueue.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: checks each response against the scoreboard, checks the taps
    // one cycle later, and checks that the ready handshake stays low while busy.
    always @(negedge clk) begin : monitor
        expect_t e;
        int      d;
        if (!rst) begin
            if (tapPending) begin
                checkOutput("mstatusTap", mstatusOut, tapExp.mstatus);
                checkOutput("mieTap",     mieOut,     tapExp.mie);
                checkOutput("mtvecTap",   mtvecOut,   tapExp.mtvec);
                checkOutput("mepcTap",    mepcOut,    tapExp.mepc);
                tapPending = 1'b0;
            end
            if (respValid) begin
                if (sbQueue.size() == 0) begin
                    nCompares++;
                    nMiss++;
                    $display("[TB] FAIL unexpectedResp: got respValid=1, expected no response (t=%0t)", $time);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("respRData",   respRData, e.rdata);
                    checkOutput("respIllegal", {31'b0, respIllegal}, {31'b0, e.illegal});
                    checkOutput("respLatency", cycleCnt, e.acceptCycle + 1);
                    tapExp     = e;
                    tapPending = 1'b1;
                end
            end
            if (trackBusy) begin
                d = cycleCnt - lastAccept;
                if (d == 0 || d == 1) checkOutput("busyReady",  {31'b0, reqReady}, 32'd0);
                else if (d == 2)      checkOutput("readyAgain", {31'b0, reqReady}, 32'd1);
            end
        end
    end

    initial begin
        logic [11:0] a;
        rst        = 1'b1;
        reqValid   = 1'b0;
        reqOp      = 2'b00;
        reqAddr    = 12'h000;
        reqWData   = 32'h0;
        reqSrcZero = 1'b0;
        curPriv    = 2'b11;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Values right after reset.
        checkOutput("resetReady",     {31'b0, reqReady},    32'd1);
        checkOutput("resetRespValid", {31'b0, respValid},   32'd0);
        checkOutput("resetRData",     respRData,            32'd0);
        checkOutput("resetIllegal",   {31'b0, respIllegal}, 32'd0);
        checkOutput("resetMtvec",     mtvecOut,             32'h0);
        checkOutput("resetMstatus",   mstatusOut,           32'h0);

        // Plain RW to mtvec.
        applyStimulus(2'b01, 12'h305, 32'h0000_1000, 1'b0, 2'b11, 1'b1);
        waitIdle();
        checkOutput("mtvecAfterRw", mtvecOut, 32'h0000_1000);

        // Set, then clear, on mie.
        applyStimulus(2'b01, 12'h304, 32'h0000_0888, 1'b0, 2'b11, 1'b1);
        applyStimulus(2'b10, 12'h304, 32'h0000_0001, 1'b0, 2'b11, 1'b1);
        applyStimulus(2'b11, 12'h304, 32'h0000_0808, 1'b0, 2'b11, 1'b1);
        waitIdle();
        checkOutput("mieAfterRsRc", mieOut, 32'h0000_0081);

        // Zero source suppresses the RS write but not the RW write.
        applyStimulus(2'b01, 12'h341, 32'h0000_0040, 1'b0, 2'b11, 1'b1);
        applyStimulus(2'b10, 12'h341, 32'hFFFF_FFFF, 1'b1, 2'b11, 1'b1);
        waitIdle();
        checkOutput("mepcRsZero", mepcOut, 32'h0000_0040);
        applyStimulus(2'b01, 12'h341, 32'h0000_0000, 1'b1, 2'b11, 1'b1);
        waitIdle();
        checkOutput("mepcRwZero", mepcOut, 32'h0000_0000);

        // Non-existing address, privilege violation, and a legal user access.
        applyStimulus(2'b01, 12'h7C0, 32'h1234_5678, 1'b0, 2'b11, 1'b1);
        applyStimulus(2'b01, 12'h300, 32'h0000_1888, 1'b0, 2'b00, 1'b1);
        applyStimulus(2'b01, 12'h041, 32'h0000_0123, 1'b0, 2'b00, 1'b1);
        waitIdle();
        checkOutput("mstatusUntouched", mstatusOut, 32'h0);

        // Reserved op, then requests held valid back to back.
        applyStimulus(2'b00, 12'h300, 32'hFFFF_FFFF, 1'b0, 2'b11, 1'b1);
        applyStimulus(2'b01, 12'h343, 32'h0000_0055, 1'b0, 2'b11, 1'b1);
        checkOutput("backToBackWait", lastWaits, 32'd2);
        applyStimulus(2'b01, 12'h344, 32'h0000_0066, 1'b0, 2'b11, 1'b1);
        checkOutput("backToBackWait2", lastWaits, 32'd2);
        waitIdle();

        // Reset during READ aborts the request.
        applyStimulus(2'b01, 12'h342, 32'h0000_000B, 1'b0, 2'b11, 1'b0);
        rst       = 1'b1;
        reqValid  = 1'b0;
        trackBusy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("abortReady",     {31'b0, reqReady},  32'd1);
        checkOutput("abortRespValid", {31'b0, respValid}, 32'd0);
        applyStimulus(2'b10, 12'h342, 32'h0000_0000, 1'b1, 2'b11, 1'b1);
        waitIdle();

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) a = 12'(implAddrs[$urandom_range(0, 18)]);
            else if ($urandom_range(0, 1) == 0) a = 12'(badAddrs[$urandom_range(0, 4)]);
            else a = 12'($urandom_range(0, 4095));
            applyStimulus(2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 1'b1);
            if ($urandom_range(0, 3) == 0) waitIdle();
        end
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiss);
        $finish;
    end

endmodule
